writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_pkg.sv | 16 +
 rtl/writeback_slot.sv | 53 +++++
 rtl/writeback_arbiter.sv | 160 ++++++++++++++++
 tb/tb_writeback_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// writeback_arbiter_pkg
// Shared definitions for the writeback arbiter and its per-source slots.
// Width derivations live here so the register file and the arbiter agree on
// how wide a register index is for a given register count.
// No ports (package).
// -----------------------------------------------------------------------------
package writeback_arbiter_pkg;

  // Index width needed to address `count` items; never narrower than 1 bit so
  // degenerate configurations (a single register or source) still elaborate.
  function automatic int index_size(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/writeback_slot.sv
// -----------------------------------------------------------------------------
// writeback_slot
// One pending writeback entry {index, data} held on behalf of a single result
// producer until the arbiter grants it a register-file write port.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   synchronous, active-high; clears the pending flag only
//   load        in   capture load_index/load_data and mark pending
//   clear       in   entry granted this cycle; drop pending unless reloaded
//   load_index  in   destination register of the incoming result
//   load_data   in   value of the incoming result
//   pending     out  entry holds a result not yet written back
//   index       out  stored destination register
//   data        out  stored result value
// -----------------------------------------------------------------------------
module writeback_slot #(
  parameter int SIZE       = 32,
  parameter int INDEX_SIZE = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  clear,
  input  logic [INDEX_SIZE-1:0] load_index,
  input  logic [SIZE-1:0]       load_data,
  output logic                  pending,
  output logic [INDEX_SIZE-1:0] index,
  output logic [SIZE-1:0]       data
);

  // A load on the same edge as a clear wins: the old entry leaves through the
  // write port while the new one takes its place, sustaining one result per
  // cycle from a single source.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (load) begin
      pending <= 1'b1;
    end else if (clear) begin
      pending <= 1'b0;
    end
  end

  // Payload carries no reset; it is meaningless while pending is low.
  always_ff @(posedge clock) begin
    if (load) begin
      index <= load_index;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Collects results from SOURCE_COUNT producers, holds one pending entry per
// producer and forwards up to WRITE_COUNT of them per cycle to the register
// file write ports, round-robin, never writing the same register twice in one
// cycle.
//
// Configuration macro: WRITEBACK_ARBITER_BYPASS_EN
//   undefined (default): write ports are registered; a result accepted at one
//                        edge appears on the write port after the next edge.
//   defined            : write ports show the current cycle's grants
//                        combinationally; the register file commits at the
//                        same edge that clears the pending entry.
//
// Ports
//   clock         in   rising-edge clock
//   reset         in   synchronous, active-high
//   source_valid  in   [SOURCE_COUNT]                       result offered
//   source_ready  out  [SOURCE_COUNT]                       result accepted
//   source_index  in   [SOURCE_COUNT*REGISTER_INDEX_SIZE]   destination, flat
//   source_data   in   [SOURCE_COUNT*SIZE]                  value, flat
//   write_enable  out  [WRITE_COUNT]                        write strobe
//   write_index   out  [WRITE_COUNT*REGISTER_INDEX_SIZE]    destination, flat
//   write_data    out  [WRITE_COUNT*SIZE]                   value, flat
// -----------------------------------------------------------------------------
module writeback_arbiter
  import writeback_arbiter_pkg::*;
#(
  parameter  int SIZE                = 32,
  parameter  int REGISTER_COUNT      = 31,
  parameter  int SOURCE_COUNT        = 4,
  parameter  int WRITE_COUNT         = 2,
  localparam int REGISTER_INDEX_SIZE = index_size(REGISTER_COUNT)
) (
  input  logic                                       clock,
  input  logic                                       reset,
  input  logic [SOURCE_COUNT-1:0]                    source_valid,
  output logic [SOURCE_COUNT-1:0]                    source_ready,
  input  logic [SOURCE_COUNT*REGISTER_INDEX_SIZE-1:0] source_index,
  input  logic [SOURCE_COUNT*SIZE-1:0]               source_data,
  output logic [WRITE_COUNT-1:0]                     write_enable,
  output logic [WRITE_COUNT*REGISTER_INDEX_SIZE-1:0] write_index,
  output logic [WRITE_COUNT*SIZE-1:0]                write_data
);

  localparam int POINTER_SIZE = index_size(SOURCE_COUNT);

  logic [SOURCE_COUNT-1:0]        pending;
  logic [SOURCE_COUNT-1:0]        granted;
  logic [SOURCE_COUNT-1:0]        load;
  logic [REGISTER_INDEX_SIZE-1:0] slot_index [SOURCE_COUNT];
  logic [SIZE-1:0]                slot_data  [SOURCE_COUNT];

  logic [WRITE_COUNT-1:0]         grant_enable;
  logic [REGISTER_INDEX_SIZE-1:0] grant_index [WRITE_COUNT];
  logic [SIZE-1:0]                grant_data  [WRITE_COUNT];

  logic [POINTER_SIZE-1:0]        rr_pointer;
  logic [POINTER_SIZE-1:0]        rr_next;

  // Ready looks only at slot occupancy and this cycle's grant, never at
  // source_valid, so producers can use it without a combinational loop.
  assign source_ready = ~pending | granted;
  assign load         = source_valid & source_ready;

  for (genvar s = 0; s < SOURCE_COUNT; s++) begin : g_slot
    writeback_slot #(
      .SIZE       (SIZE),
      .INDEX_SIZE (REGISTER_INDEX_SIZE)
    ) u_slot (
      .clock      (clock),
      .reset      (reset),
      .load       (load[s]),
      .clear      (granted[s]),
      .load_index (source_index[s*REGISTER_INDEX_SIZE +: REGISTER_INDEX_SIZE]),
      .load_data  (source_data[s*SIZE +: SIZE]),
      .pending    (pending[s]),
      .index      (slot_index[s]),
      .data       (slot_data[s])
    );
  end

  // Walk the sources starting at rr_pointer. Each pending entry whose index
  // differs from every entry already granted this cycle takes the next free
  // write port; a clashing entry is skipped and simply stays pending.
  always_comb begin
    int                      count;
    logic                    conflict;
    logic [POINTER_SIZE-1:0] s;
    granted      = '0;
    grant_enable = '0;
    for (int p = 0; p < WRITE_COUNT; p++) begin
      grant_index[p] = '0;
      grant_data[p]  = '0;
    end
    rr_next  = rr_pointer;
    count    = 0;
    conflict = 1'b0;
    s        = '0;
    for (int k = 0; k < SOURCE_COUNT; k++) begin
      s        = POINTER_SIZE'((int'(rr_pointer) + k) % SOURCE_COUNT);
      conflict = 1'b0;
      for (int p = 0; p < WRITE_COUNT; p++) begin
        if (p < count && grant_index[p] == slot_index[s]) begin
          conflict = 1'b1;
        end
      end
      if (pending[s] && count < WRITE_COUNT && !conflict) begin
        granted[s] = 1'b1;
        for (int p = 0; p < WRITE_COUNT; p++) begin
          if (p == count) begin
            grant_enable[p] = 1'b1;
            grant_index[p]  = slot_index[s];
            grant_data[p]   = slot_data[s];
          end
        end
        count   = count + 1;
        rr_next = POINTER_SIZE'((int'(s) + 1) % SOURCE_COUNT);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_pointer <= '0;
    end else begin
      rr_pointer <= rr_next;
    end
  end

`ifdef WRITEBACK_ARBITER_BYPASS_EN
  // Grants go straight to the register file; masking with reset keeps a
  // reset edge from committing anything.
  always_comb begin
    write_enable = grant_enable & {WRITE_COUNT{~reset}};
    write_index  = '0;
    write_data   = '0;
    for (int p = 0; p < WRITE_COUNT; p++) begin
      write_index[p*REGISTER_INDEX_SIZE +: REGISTER_INDEX_SIZE] = grant_index[p];
      write_data[p*SIZE +: SIZE]                                = grant_data[p];
    end
  end
`else
  // Grant -> write port register boundary.
  always_ff @(posedge clock) begin
    if (reset) begin
      write_enable <= '0;
      write_index  <= '0;
      write_data   <= '0;
    end else begin
      write_enable <= grant_enable;
      for (int p = 0; p < WRITE_COUNT; p++) begin
        write_index[p*REGISTER_INDEX_SIZE +: REGISTER_INDEX_SIZE] <= grant_index[p];
        write_data[p*SIZE +: SIZE]                                <= grant_data[p];
      end
    end
  end
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
// Directed scenarios plus a randomized run against a cycle-level reference
// model of the arbiter. Honors WRITEBACK_ARBITER_BYPASS_EN for write latency.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_writeback_arbiter;

  localparam int SIZE = 32;
  localparam int RC   = 31;
  localparam int SC   = 4;
  localparam int WC   = 2;
  localparam int IS   = 5;
`ifdef WRITEBACK_ARBITER_BYPASS_EN
  localparam int LAT  = 1;
`else
  localparam int LAT  = 2;
`endif

  logic                 clock = 1'b0;
  logic                 reset;
  logic [SC-1:0]        source_valid;
  logic [SC-1:0]        source_ready;
  logic [SC*IS-1:0]     source_index;
  logic [SC*SIZE-1:0]   source_data;
  logic [WC-1:0]        write_enable;
  logic [WC*IS-1:0]     write_index;
  logic [WC*SIZE-1:0]   write_data;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  writeback_arbiter #(
    .SIZE           (SIZE),
    .REGISTER_COUNT (RC),
    .SOURCE_COUNT   (SC),
    .WRITE_COUNT    (WC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_index (source_index),
    .source_data  (source_data),
    .write_enable (write_enable),
    .write_index  (write_index),
    .write_data   (write_data)
  );

  // ---------------- reference model ----------------
  bit              m_pend [SC];
  logic [IS-1:0]   m_idx  [SC];
  logic [SIZE-1:0] m_dat  [SC];
  int              m_rr;

  bit              g_take [SC];
  bit              g_en   [WC];
  logic [IS-1:0]   g_idx  [WC];
  logic [SIZE-1:0] g_dat  [WC];
  int              g_last;

  bit              e_en   [WC];
  logic [IS-1:0]   e_idx  [WC];
  logic [SIZE-1:0] e_dat  [WC];

  // List the pending sources in round-robin order, then hand out ports to the
  // first ones whose register differs from everything already chosen.
  task automatic model_grants();
    int order[$];
    int n;
    order = {};
    for (int k = 0; k < SC; k++)
      if (m_pend[(m_rr + k) % SC]) order.push_back((m_rr + k) % SC);
    for (int s = 0; s < SC; s++) g_take[s] = 0;
    for (int p = 0; p < WC; p++) begin g_en[p] = 0; g_idx[p] = '0; g_dat[p] = '0; end
    n = 0;
    g_last = -1;
    foreach (order[i]) begin
      int src;
      bit clash;
      src = order[i];
      clash = 0;
      for (int p = 0; p < n; p++) if (g_idx[p] == m_idx[src]) clash = 1;
      if (!clash && n < WC) begin
        g_take[src] = 1;
        g_en[n] = 1;
        g_idx[n] = m_idx[src];
        g_dat[n] = m_dat[src];
        n++;
        g_last = src;
      end
    end
  endtask

  // Advance DUT and model by one clock edge; returns at posedge + 1.
  task automatic cycle();
    bit acc [SC];
    model_grants();
    for (int s = 0; s < SC; s++) acc[s] = source_valid[s] && (!m_pend[s] || g_take[s]);
    @(posedge clock);
    if (reset) begin
      for (int s = 0; s < SC; s++) m_pend[s] = 0;
      m_rr = 0;
    end else begin
      for (int s = 0; s < SC; s++) if (g_take[s]) m_pend[s] = 0;
      for (int s = 0; s < SC; s++)
        if (acc[s]) begin
          m_pend[s] = 1;
          m_idx[s]  = source_index[s*IS +: IS];
          m_dat[s]  = source_data[s*SIZE +: SIZE];
        end
      if (g_last >= 0) m_rr = (g_last + 1) % SC;
    end
`ifdef WRITEBACK_ARBITER_BYPASS_EN
    model_grants();
    for (int p = 0; p < WC; p++) begin e_en[p] = g_en[p]; e_idx[p] = g_idx[p]; e_dat[p] = g_dat[p]; end
`else
    for (int p = 0; p < WC; p++) begin
      e_en[p]  = reset ? 1'b0 : g_en[p];
      e_idx[p] = reset ? '0 : g_idx[p];
      e_dat[p] = reset ? '0 : g_dat[p];
    end
`endif
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    source_valid = '0;
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (source_ready !== 4'b1111) begin errors++; $display("FAIL reset_ready got=%b want=1111", source_ready); end
    checks++; if (write_enable !== 2'b00) begin errors++; $display("FAIL reset_we got=%b want=00", write_enable); end
    checks++; if (write_index !== '0) begin errors++; $display("FAIL reset_widx got=%h want=0", write_index); end
    checks++; if (write_data !== '0) begin errors++; $display("FAIL reset_wdata got=%h want=0", write_data); end
    checks++; if (dut.rr_pointer !== 2'd0) begin errors++; $display("FAIL reset_rr got=%0d want=0", dut.rr_pointer); end
  endtask

  task automatic test_single();
    do_reset();
    source_valid = 4'b0100;
    source_index[2*IS +: IS] = 5'd5;
    source_data[2*SIZE +: SIZE] = 32'hDEADBEEF;
    cycle();
    source_valid = '0;
`ifndef WRITEBACK_ARBITER_BYPASS_EN
    checks++; if (write_enable !== 2'b00) begin errors++; $display("FAIL single_early got=%b want=00", write_enable); end
    cycle();
`endif
    checks++; if (write_enable !== 2'b01) begin errors++; $display("FAIL single_we got=%b want=01", write_enable); end
    checks++; if (write_index !== {5'd0, 5'd5}) begin errors++; $display("FAIL single_idx got=%h want=%h", write_index, {5'd0, 5'd5}); end
    checks++; if (write_data !== {32'h0, 32'hDEADBEEF}) begin errors++; $display("FAIL single_data got=%h want=00000000deadbeef", write_data); end
    cycle();
    checks++; if (write_enable !== 2'b00) begin errors++; $display("FAIL single_after got=%b want=00", write_enable); end
  endtask

  task automatic test_four();
    do_reset();
    source_valid = 4'b1111;
    for (int s = 0; s < SC; s++) begin
      source_index[s*IS +: IS] = IS'(s + 1);
      source_data[s*SIZE +: SIZE] = 32'hA0 + s;
    end
    cycle();
    source_valid = '0;
    repeat (LAT - 1) cycle();
    checks++; if (write_enable !== 2'b11) begin errors++; $display("FAIL four_we1 got=%b want=11", write_enable); end
    checks++; if (write_index !== {5'd2, 5'd1}) begin errors++; $display("FAIL four_idx1 got=%h want=%h", write_index, {5'd2, 5'd1}); end
    checks++; if (write_data !== {32'hA1, 32'hA0}) begin errors++; $display("FAIL four_data1 got=%h want=000000a1000000a0", write_data); end
    cycle();
    checks++; if (write_enable !== 2'b11) begin errors++; $display("FAIL four_we2 got=%b want=11", write_enable); end
    checks++; if (write_index !== {5'd4, 5'd3}) begin errors++; $display("FAIL four_idx2 got=%h want=%h", write_index, {5'd4, 5'd3}); end
    checks++; if (write_data !== {32'hA3, 32'hA2}) begin errors++; $display("FAIL four_data2 got=%h want=000000a3000000a2", write_data); end
    cycle();
    checks++; if (write_enable !== 2'b00) begin errors++; $display("FAIL four_we3 got=%b want=00", write_enable); end
    checks++; if (dut.rr_pointer !== 2'd0) begin errors++; $display("FAIL four_rr got=%0d want=0", dut.rr_pointer); end
  endtask

  task automatic test_conflict();
    do_reset();
    source_valid = 4'b0011;
    source_index[0 +: IS] = 5'd7;
    source_index[IS +: IS] = 5'd7;
    source_data[0 +: SIZE] = 32'h11;
    source_data[SIZE +: SIZE] = 32'h22;
    cycle();
    source_valid = '0;
    repeat (LAT - 1) cycle();
    checks++; if (write_enable !== 2'b01) begin errors++; $display("FAIL conflict_we1 got=%b want=01", write_enable); end
    checks++; if (write_index[0 +: IS] !== 5'd7) begin errors++; $display("FAIL conflict_idx1 got=%0d want=7", write_index[0 +: IS]); end
    checks++; if (write_data[0 +: SIZE] !== 32'h11) begin errors++; $display("FAIL conflict_data1 got=%h want=11", write_data[0 +: SIZE]); end
    cycle();
    checks++; if (write_enable !== 2'b01) begin errors++; $display("FAIL conflict_we2 got=%b want=01", write_enable); end
    checks++; if (write_data[0 +: SIZE] !== 32'h22) begin errors++; $display("FAIL conflict_data2 got=%h want=22", write_data[0 +: SIZE]); end
    cycle();
    checks++; if (write_enable !== 2'b00) begin errors++; $display("FAIL conflict_we3 got=%b want=00", write_enable); end
  endtask

  task automatic test_back_to_back();
    int n;
    int j;
    n = 16;
    do_reset();
    for (int i = 0; i < n + LAT; i++) begin
      if (i < n) begin
        source_valid = 4'b0001;
        source_index[0 +: IS] = IS'((i + 3) % RC);
        source_data[0 +: SIZE] = 32'h100 + i;
      end else begin
        source_valid = '0;
      end
      #1;
      if (i < n) begin
        checks++; if (source_ready[0] !== 1'b1) begin errors++; $display("FAIL stream_ready i=%0d got=%b want=1", i, source_ready[0]); end
      end
      cycle();
      j = i - (LAT - 1);
      if (j >= 0 && j < n) begin
        checks++;
        if (write_enable !== 2'b01 || write_data[0 +: SIZE] !== 32'h100 + j) begin
          errors++;
          $display("FAIL stream_write j=%0d got we=%b data=%h want we=01 data=%h", j, write_enable, write_data[0 +: SIZE], 32'h100 + j);
        end
      end
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    source_valid = 4'b1111;
    for (int s = 0; s < SC; s++) begin
      source_index[s*IS +: IS] = IS'(s + 10);
      source_data[s*SIZE +: SIZE] = 32'hC0 + s;
    end
    cycle();
    source_valid = '0;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    checks++; if (source_ready !== 4'b1111) begin errors++; $display("FAIL rstpend_ready got=%b want=1111", source_ready); end
    checks++; if (write_enable !== 2'b00) begin errors++; $display("FAIL rstpend_we0 got=%b want=00", write_enable); end
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (write_enable !== 2'b00) begin errors++; $display("FAIL rstpend_we i=%0d got=%b want=00", i, write_enable); end
    end
  endtask

  task automatic test_random();
    logic [SC-1:0]      exp_ready;
    logic [WC-1:0]      exp_we;
    logic [WC*IS-1:0]   exp_idx;
    logic [WC*SIZE-1:0] exp_dat;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      source_valid = SC'($urandom);
      for (int s = 0; s < SC; s++) begin
        source_index[s*IS +: IS] = IS'($urandom_range(0, 3));
        source_data[s*SIZE +: SIZE] = $urandom;
      end
      #1;
      model_grants();
      for (int s = 0; s < SC; s++) exp_ready[s] = !m_pend[s] || g_take[s];
      checks++; if (source_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, source_ready, exp_ready); end
      cycle();
      for (int p = 0; p < WC; p++) begin
        exp_we[p] = e_en[p];
        exp_idx[p*IS +: IS] = e_idx[p];
        exp_dat[p*SIZE +: SIZE] = e_dat[p];
      end
      checks++;
      if (write_enable !== exp_we || write_index !== exp_idx || write_data !== exp_dat) begin
        errors++;
        $display("FAIL rand_write c=%0d got we=%b idx=%h data=%h want we=%b idx=%h data=%h",
                 c, write_enable, write_index, write_data, exp_we, exp_idx, exp_dat);
      end
    end
    source_valid = '0;
  endtask

  initial begin
    reset = 1'b1;
    source_valid = '0;
    source_index = '0;
    source_data = '0;
    m_rr = 0;
    for (int s = 0; s < SC; s++) begin m_pend[s] = 0; m_idx[s] = '0; m_dat[s] = '0; end
    test_reset();
    test_single();
    test_four();
    test_conflict();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
